// File: rtl/layers_serialize_pkg.sv
// Shared definitions for the result-word serializer: config address map,
// FSM state encoding and counter sizing helper.
package layers_serialize_pkg;

    // First config slot after the layer-stage registers.
    localparam int unsigned CFG_RESULTS = 7;
    localparam int unsigned FRAME_LEN_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layers_serialize.sv
// Serializes one DEPTH_NB x IMG_WIDTH result word into STR_WIDTH beats, lane 0
// first, and marks the final beat of each configured frame with str_last.
module layers_serialize
    import layers_serialize_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int DEPTH_NB   = 16,
    parameter int IMG_WIDTH  = 16,
    parameter int STR_WIDTH  = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [DEPTH_NB*IMG_WIDTH-1:0] up_data,
    input  logic                          up_val,
    output logic                          up_rdy,
    output logic [STR_WIDTH-1:0]          str_data,
    output logic                          str_val,
    output logic                          str_last,
    input  logic                          str_rdy,
    output logic                          frame_done
);

    localparam int WORD_W = DEPTH_NB * IMG_WIDTH;
    localparam int BEATS  = WORD_W / STR_WIDTH;
    localparam int BCW    = cnt_width(BEATS);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    if (WORD_W % STR_WIDTH != 0) begin : g_bad_width
        $error("STR_WIDTH must divide DEPTH_NB*IMG_WIDTH exactly");
    end

    ser_state_t             state;
    logic [WORD_W-1:0]      shreg;
    logic [BCW-1:0]         beat_cnt;
    logic [FRAME_LEN_W-1:0] word_cnt;
    logic [FRAME_LEN_W-1:0] word_cnt_nx;
    logic [FRAME_LEN_W-1:0] frame_len;
    logic [FRAME_LEN_W-1:0] frame_len_nx;

    logic last_beat;
    logic beat_fire;
    logic word_done;
    logic frame_end;
    logic accept;
    logic unused_cfg;

    assign unused_cfg = ^cfg_data;

    assign last_beat = (state == SHIFT) && (beat_cnt == LAST_BEAT);
    assign beat_fire = (state == SHIFT) && str_rdy;
    assign word_done = last_beat && str_rdy;
    assign frame_end = word_done && str_last;

    assign str_val  = (state == SHIFT);
    assign str_data = shreg[STR_WIDTH-1:0];
    assign str_last = last_beat && (frame_len != '0) &&
                      (word_cnt == frame_len - FRAME_LEN_W'(1));

    // str_rdy feeds up_rdy combinationally so a new word loads on the last beat.
    assign up_rdy = rst_n && ((state == EMPTY) || word_done);
    assign accept = up_val && up_rdy;

    // A zero frame length pins the count at 0, so every word starts a new frame
    // and a later config write is picked up on the very next word.
    always_comb begin
        word_cnt_nx = word_cnt;
        if (word_done) begin
            if (frame_end || frame_len == '0)
                word_cnt_nx = '0;
            else
                word_cnt_nx = word_cnt + FRAME_LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= EMPTY;
            shreg        <= '0;
            beat_cnt     <= '0;
            word_cnt     <= '0;
            frame_len    <= '0;
            frame_len_nx <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= frame_end;
            word_cnt   <= word_cnt_nx;
            if (cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_RESULTS))
                frame_len_nx <= cfg_data[FRAME_LEN_W-1:0];

            // Frame length is sampled by the word that opens a frame.
            if (accept) begin
                state    <= SHIFT;
                shreg    <= up_data;
                beat_cnt <= '0;
                if (word_cnt_nx == '0)
                    frame_len <= frame_len_nx;
            end else if (word_done) begin
                state <= EMPTY;
            end else if (beat_fire) begin
                shreg    <= shreg >> STR_WIDTH;
                beat_cnt <= beat_cnt + BCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_layers_serialize.sv
// Bench for layers_serialize: directed vector table, multi-cycle corner sequences
// and a randomized run against a queue-based beat scoreboard.
module tb_layers_serialize;
    import layers_serialize_pkg::*;

    localparam int DEPTH_NB  = 4;
    localparam int IMG_WIDTH = 16;
    localparam int STR_WIDTH = 16;
    localparam int WORD_W    = DEPTH_NB * IMG_WIDTH;
    localparam int BEATS     = WORD_W / STR_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [31:0]          cfg_data;
    logic [4:0]           cfg_addr;
    logic                 cfg_valid;
    logic [WORD_W-1:0]    up_data;
    logic                 up_val;
    logic                 up_rdy;
    logic [STR_WIDTH-1:0] str_data;
    logic                 str_val;
    logic                 str_last;
    logic                 str_rdy;
    logic                 frame_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    layers_serialize #(
        .CFG_DWIDTH(32), .CFG_AWIDTH(5), .DEPTH_NB(DEPTH_NB),
        .IMG_WIDTH(IMG_WIDTH), .STR_WIDTH(STR_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_addr(cfg_addr),
        .cfg_valid(cfg_valid), .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
        .str_data(str_data), .str_val(str_val), .str_last(str_last),
        .str_rdy(str_rdy), .frame_done(frame_done)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard: each accepted word becomes BEATS queued beats; the DUT holds at
    // most one word, so the queue depth says exactly what the outputs must be.
    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t sb_q[$];
    int    m_len = 0, m_widx = 0, m_pend = 0;
    logic  m_done = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("sb_rdy_in_reset", up_rdy, 0);
            sb_q.delete();
            m_len = 0; m_widx = 0; m_pend = 0; m_done = 1'b0;
        end else begin
            chk("sb_val", str_val, sb_q.size() != 0);
            if (sb_q.size() != 0 && str_val) begin
                chk("sb_data", str_data, sb_q[0].d);
                chk("sb_last", str_last, sb_q[0].l);
            end
            chk("sb_up_rdy", up_rdy, sb_q.size() == 0 || (sb_q.size() == 1 && str_rdy));
            chk("sb_frame_done", frame_done, m_done);
            m_done = 1'b0;
            if (str_val && str_rdy && sb_q.size() != 0) begin
                m_done = sb_q[0].l;
                void'(sb_q.pop_front());
            end
            if (up_val && up_rdy) begin
                logic [63:0] w;
                bit is_last;
                w = up_data;
                if (m_widx == 0) m_len = m_pend;
                is_last = (m_len != 0) && (m_widx == m_len - 1);
                for (int i = 0; i < BEATS; i++)
                    sb_q.push_back('{w[16*i +: 16], (i == BEATS - 1) && is_last});
                m_widx = (m_len == 0 || is_last) ? 0 : m_widx + 1;
            end
            if (cfg_valid && cfg_addr == 5'(CFG_RESULTS))
                m_pend = int'(cfg_data[15:0]);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        up_val = 0; cfg_valid = 0; str_rdy = 1; rst_n = 0;
        step(); step();
        rst_n = 1;
    endtask

    task automatic cfg_write(input int val);
        cfg_valid = 1; cfg_addr = 5'(CFG_RESULTS); cfg_data = 32'(val);
        step();
        cfg_valid = 0;
    endtask

    // Returns one cycle after acceptance, i.e. in the cycle of the first beat.
    task automatic push_word(input logic [63:0] w);
        int n = 0;
        up_data = w; up_val = 1;
        @(negedge clk);
        while (!up_rdy && n < 50) begin
            step(); @(negedge clk); n++;
        end
        chk("accept_in_time", up_rdy, 1);
        step();
        up_val = 0;
    endtask

    typedef struct {
        logic [63:0] word;
        int          flen;
        logic [15:0] beats [4];
        logic        last;
    } vec_t;

    vec_t vecs [4];

    task automatic set_vec(input int i, input logic [63:0] w, input int fl,
                           input logic [15:0] b0, input logic [15:0] b1,
                           input logic [15:0] b2, input logic [15:0] b3, input logic l);
        vecs[i].word = w; vecs[i].flen = fl; vecs[i].last = l;
        vecs[i].beats[0] = b0; vecs[i].beats[1] = b1;
        vecs[i].beats[2] = b2; vecs[i].beats[3] = b3;
    endtask

    task automatic run_vec(input vec_t v, input bit with_reset);
        if (with_reset) do_reset();
        str_rdy = 1;
        cfg_write(v.flen);
        push_word(v.word);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("vec_val", str_val, 1);
            chk("vec_data", str_data, v.beats[i]);
            chk("vec_last", str_last, (i == 3) && v.last);
            chk("vec_up_rdy", up_rdy, i == 3);
            step();
        end
        @(negedge clk);
        chk("vec_frame_done", frame_done, v.last);
        chk("vec_idle", str_val, 0);
        step();
    endtask

    logic [63:0] stream_words [8];

    task automatic run_stream(input string tag, input int n, input int flen,
                              input int cfg_at, input int cfg_val,
                              input logic [7:0] exp_mask, input int exp_done);
        int k = 0, b = 0, gaps = 0, dones = 0, data_err = 0, rdy_err = 0, last_err = 0;
        bit started = 0, cfg_sent = 0;
        logic [7:0]  mask = '0;
        logic [63:0] w;
        do_reset();
        cfg_write(flen);
        str_rdy = 1;
        for (int c = 0; c < 40; c++) begin
            up_val = (k < n);
            up_data = stream_words[(k < n) ? k : 0];
            cfg_valid = (k == cfg_at) && !cfg_sent;
            cfg_addr = 5'(CFG_RESULTS); cfg_data = 32'(cfg_val);
            @(negedge clk);
            if (cfg_valid) cfg_sent = 1;
            if (str_val) begin
                started = 1;
                w = stream_words[b / 4];
                if (str_data !== w[16*(b % 4) +: 16]) data_err++;
                if (up_rdy !== (b % 4 == 3)) rdy_err++;
                if (str_last) begin
                    mask[b / 4] = 1'b1;
                    if (b % 4 != 3) last_err++;
                end
                b++;
            end else if (started && b < 4 * n) begin
                gaps++;
            end
            if (frame_done) dones++;
            if (up_val && up_rdy) k++;
            step();
        end
        up_val = 0; cfg_valid = 0;
        chk({tag, "_beats"}, 64'(b), 64'(4 * n));
        chk({tag, "_gaps"}, 64'(gaps), 0);
        chk({tag, "_data"}, 64'(data_err), 0);
        chk({tag, "_up_rdy"}, 64'(rdy_err), 0);
        chk({tag, "_last_pos"}, 64'(last_err), 0);
        chk({tag, "_last_words"}, mask, exp_mask);
        chk({tag, "_frame_done"}, 64'(dones), 64'(exp_done));
    endtask

    initial begin
        logic [15:0] bp_dat [7];
        bit          bp_rdy [7];
        bit          bp_urdy [7];
        vec_t        rv;

        rst_n = 0; up_val = 0; up_data = '0; cfg_valid = 0; cfg_addr = '0;
        cfg_data = '0; str_rdy = 1;
        do_reset();

        @(negedge clk);
        chk("reset_str_val", str_val, 0);
        chk("reset_str_last", str_last, 0);
        chk("reset_str_data", str_data, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_up_rdy", up_rdy, 1);
        step();

        set_vec(0, 64'h4444_3333_2222_1111, 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
        set_vec(1, 64'h0123_4567_89AB_CDEF, 0, 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123, 1'b0);
        set_vec(2, 64'hFFFF_0000_FFFF_0000, 2, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);
        set_vec(3, 64'h8000_0001_7FFF_FFFE, 1, 16'hFFFE, 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
        for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b1);

        for (int i = 0; i < 8; i++) stream_words[i] = {$urandom, $urandom};
        run_stream("b2b", 3, 3, -1, 0, 8'h04, 1);
        run_stream("freerun", 5, 0, -1, 0, 8'h00, 0);
        run_stream("cfg_mid", 6, 2, 1, 4, 8'h22, 2);

        // Backpressure on beat 2 for three cycles.
        bp_rdy  = '{1, 1, 0, 0, 0, 1, 1};
        bp_dat  = '{16'h1111, 16'h2222, 16'h3333, 16'h3333, 16'h3333, 16'h3333, 16'h4444};
        bp_urdy = '{0, 0, 0, 0, 0, 0, 1};
        do_reset();
        cfg_write(1);
        push_word(64'h4444_3333_2222_1111);
        for (int i = 0; i < 7; i++) begin
            str_rdy = bp_rdy[i];
            @(negedge clk);
            chk("bp_val", str_val, 1);
            chk("bp_data", str_data, bp_dat[i]);
            chk("bp_up_rdy", up_rdy, bp_urdy[i]);
            step();
        end
        str_rdy = 1;
        @(negedge clk);
        chk("bp_frame_done", frame_done, 1);
        chk("bp_idle", str_val, 0);
        step();

        // Reset while beat 1 of a word is on the bus.
        do_reset();
        cfg_write(1);
        push_word(64'h4444_3333_2222_1111);
        step();
        rst_n = 0;
        @(negedge clk);
        chk("rst_mid_up_rdy_low", up_rdy, 0);
        step();
        rst_n = 1;
        @(negedge clk);
        chk("rst_mid_val", str_val, 0);
        chk("rst_mid_data", str_data, 0);
        chk("rst_mid_up_rdy", up_rdy, 1);
        chk("rst_mid_done", frame_done, 0);
        step();
        rv.word = 64'hDDDD_CCCC_BBBB_AAAA; rv.flen = 1; rv.last = 1'b1;
        rv.beats[0] = 16'hAAAA; rv.beats[1] = 16'hBBBB;
        rv.beats[2] = 16'hCCCC; rv.beats[3] = 16'hDDDD;
        run_vec(rv, 1'b0);

        // Randomized traffic, config writes (some to other addresses) and resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            up_val    = ($urandom_range(0, 3) != 0);
            up_data   = {$urandom, $urandom};
            str_rdy   = ($urandom_range(0, 3) != 0);
            cfg_valid = ($urandom_range(0, 15) == 0);
            cfg_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(CFG_RESULTS);
            cfg_data  = {16'($urandom), 16'($urandom_range(0, 4))};
            rst_n     = ($urandom_range(0, 499) != 0);
            step();
        end
        up_val = 0; cfg_valid = 0; rst_n = 1; str_rdy = 1;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
